serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 120 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) built around one
// full-subtractor cell and a registered borrow, with valid/ready on both sides.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   diff_sh_r;
    logic               borrow_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               a_msb_r;
    logic               b_msb_r;

    logic               bit_s;
    logic               borrow_next_s;
    logic [WIDTH-1:0]   diff_next_s;

    function automatic logic fs_diff(input logic x, input logic y, input logic bin);
        return x ^ y ^ bin;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

    // Full-subtractor cell on the current LSBs and the next diff shift value.
    always_comb begin
        bit_s         = fs_diff(a_sh_r[0], b_sh_r[0], borrow_r);
        borrow_next_s = fs_borrow(a_sh_r[0], b_sh_r[0], borrow_r);
        diff_next_s   = {bit_s, diff_sh_r[WIDTH-1:1]};
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);

    // Control FSM, operand/result shift registers and result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            a_sh_r     <= '0;
            b_sh_r     <= '0;
            diff_sh_r  <= '0;
            borrow_r   <= 1'b0;
            cnt_r      <= '0;
            a_msb_r    <= 1'b0;
            b_msb_r    <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r    <= a;
                        b_sh_r    <= b;
                        diff_sh_r <= '0;
                        borrow_r  <= 1'b0;
                        cnt_r     <= '0;
                        a_msb_r   <= a[WIDTH-1];
                        b_msb_r   <= b[WIDTH-1];
                        state_r   <= RUN;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_r    <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r    <= {1'b0, b_sh_r[WIDTH-1:1]};
                    diff_sh_r <= diff_next_s;
                    borrow_r  <= borrow_next_s;
                    if (cnt_r == CNT_LAST) begin
                        // The bit produced on this edge is the result MSB.
                        cnt_r      <= '0;
                        diff       <= diff_next_s;
                        borrow_out <= borrow_next_s;
                        overflow   <= (a_msb_r != b_msb_r) && (bit_s != a_msb_r);
                        state_r    <= DONE;
                    end else begin
                        cnt_r      <= cnt_r + CNT_W'(1);
                        state_r    <= RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
